// File: rtl/pc_next_unit.sv
// Next-PC selection (increment / branch / jump / call / return) feeding the PC register,
// with a circular return-address stack and sticky overflow/underflow flags.
module pc_next_unit #(
    parameter int Index_width = 9,
    parameter int Off_width   = 9,
    parameter int Ras_depth   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [Index_width-1:0]       pc_current,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [Off_width-1:0]         branch_offset,
    input  logic                         jump,
    input  logic                         call,
    input  logic [Index_width-1:0]       jump_target,
    input  logic                         ret,
    input  logic                         flag_clr,
    output logic [Index_width-1:0]       next_value,
    output logic [$clog2(Ras_depth):0]   ras_depth,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int PW = $clog2(Ras_depth);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] FULL = DW'(Ras_depth);

    logic [Index_width-1:0] r_ras [Ras_depth];
    logic [PW-1:0]          r_top;
    logic [DW-1:0]          r_depth;
    logic                   r_ovf;
    logic                   r_unf;

    logic signed [Index_width-1:0] w_off_ext;
    logic [Index_width-1:0]        w_pc_inc;
    logic [Index_width-1:0]        w_br_tgt;
    logic [Index_width-1:0]        w_ras_top;
    logic                          w_empty;
    logic                          w_full;

    logic                   w_wr_en;
    logic [PW-1:0]          w_wr_addr;
    logic [PW-1:0]          w_top_nx;
    logic [DW-1:0]          w_depth_nx;
    logic                   w_ovf_set;
    logic                   w_unf_set;

    assign w_off_ext = $signed(branch_offset);
    assign w_pc_inc  = pc_current + 1'b1;
    assign w_br_tgt  = pc_current + w_off_ext;
    assign w_ras_top = r_ras[r_top];
    assign w_empty   = (r_depth == '0);
    assign w_full    = (r_depth == FULL);

    always_comb begin
        next_value = w_pc_inc;
        if (stall)
            next_value = pc_current;
        else if (ret)
            next_value = w_empty ? w_pc_inc : w_ras_top;
        else if (call || jump)
            next_value = jump_target;
        else if (branch_taken)
            next_value = w_br_tgt;
    end

    // r_top addresses the newest entry; a push writes one slot above it, which
    // on a full stack is the oldest entry, so overwrite falls out of the wrap.
    always_comb begin
        w_wr_en    = 1'b0;
        w_wr_addr  = r_top;
        w_top_nx   = r_top;
        w_depth_nx = r_depth;
        w_ovf_set  = 1'b0;
        w_unf_set  = 1'b0;
        if (!stall) begin
            if (call && ret) begin
                w_wr_en = 1'b1;
                if (w_empty) begin
                    w_unf_set  = 1'b1;
                    w_wr_addr  = r_top + 1'b1;
                    w_top_nx   = r_top + 1'b1;
                    w_depth_nx = DW'(1);
                end
            end else if (call) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_top + 1'b1;
                w_top_nx  = r_top + 1'b1;
                if (w_full)
                    w_ovf_set = 1'b1;
                else
                    w_depth_nx = r_depth + 1'b1;
            end else if (ret) begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_top_nx   = r_top - 1'b1;
                    w_depth_nx = r_depth - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Ras_depth; i++)
                r_ras[i] <= '0;
        end else if (w_wr_en) begin
            r_ras[w_wr_addr] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top   <= '0;
            r_depth <= '0;
        end else begin
            r_top   <= w_top_nx;
            r_depth <= w_depth_nx;
        end
    end

    // Clear is not gated by stall, and a same-edge event still sets the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~flag_clr) | w_ovf_set;
            r_unf <= (r_unf & ~flag_clr) | w_unf_set;
        end
    end

    assign ras_depth     = r_depth;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: a stack model predicts next_value per cycle,
// scenario tasks check RAS depth and sticky flags after each edge.
module tb_pc_next_unit;

    logic       clk;
    logic       rst;
    logic [8:0] pc_current;
    logic       stall;
    logic       branch_taken;
    logic [8:0] branch_offset;
    logic       jump;
    logic       call;
    logic [8:0] jump_target;
    logic       ret;
    logic       flag_clr;
    logic [8:0] next_value;
    logic [3:0] ras_depth;
    logic       ras_overflow;
    logic       ras_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    int sb[$];
    int m[$];
    bit m_ovf = 0;
    bit m_unf = 0;

    pc_next_unit #(.Index_width(9), .Off_width(9), .Ras_depth(8)) dut (
        .clk(clk), .rst(rst), .pc_current(pc_current), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .call(call), .jump_target(jump_target), .ret(ret), .flag_clr(flag_clr),
        .next_value(next_value), .ras_depth(ras_depth),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            int e;
            e = sb.pop_front();
            n_checks++;
            if (next_value !== 9'(e)) begin
                n_fail++;
                $display("FAIL next_value: got %0d expected %0d (pc=%0d)", next_value, e, pc_current);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        stall = 0; branch_taken = 0; branch_offset = 0; jump = 0;
        call = 0; jump_target = 0; ret = 0; flag_clr = 0;
    endtask

    // Called at posedge+1; applies one cycle of stimulus and returns at the next posedge+1.
    task automatic drive(input int pc, input bit cl, input bit rt, input bit jmp, input bit br,
                         input int off, input int tgt, input bit stl, input bit fc);
        int inc, so, bt, e;
        bit os, us;
        pc_current = 9'(pc); call = cl; ret = rt; jump = jmp; branch_taken = br;
        branch_offset = 9'(off); jump_target = 9'(tgt); stall = stl; flag_clr = fc;
        inc = (pc + 1) % 512;
        so  = (off >= 256) ? off - 512 : off;
        bt  = (pc + so + 512) % 512;
        if (stl)            e = pc;
        else if (rt)        e = (m.size() > 0) ? m[m.size()-1] : inc;
        else if (cl || jmp) e = tgt;
        else if (br)        e = bt;
        else                e = inc;
        sb.push_back(e);
        os = 0; us = 0;
        if (!stl) begin
            if (cl && rt) begin
                if (m.size() > 0) m[m.size()-1] = inc;
                else begin us = 1; m.push_back(inc); end
            end else if (cl) begin
                if (m.size() == 8) begin os = 1; void'(m.pop_front()); end
                m.push_back(inc);
            end else if (rt) begin
                if (m.size() > 0) void'(m.pop_back());
                else us = 1;
            end
        end
        m_ovf = (m_ovf & !fc) | os;
        m_unf = (m_unf & !fc) | us;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; pc_current = 9'd511;
        #1;
        n_checks++;
        if (next_value !== 9'd0) begin n_fail++; $display("FAIL reset_wrap: got %0d expected 0", next_value); end
        pc_current = 9'd5;
        #1;
        n_checks++;
        if (next_value !== 9'd6) begin n_fail++; $display("FAIL reset_inc: got %0d expected 6", next_value); end
        n_checks++;
        if (ras_depth !== 4'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got depth=%0d ovf=%b unf=%b expected 0/0/0", ras_depth, ras_overflow, ras_underflow);
        end
        @(negedge clk); rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_arith();
        drive(511, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(5,   0, 0, 0, 0, 0, 0, 0, 0);
        drive(2,   0, 0, 0, 1, 9'h1FD, 0, 0, 0);
        drive(500, 0, 0, 0, 1, 20, 0, 0, 0);
        drive(300, 0, 0, 0, 1, 255, 0, 0, 0);
        drive(100, 0, 0, 0, 1, 256, 0, 0, 0);
        drive(3,   0, 0, 1, 1, 4, 77, 0, 0);
        n_checks++;
        if (ras_depth !== 4'd0) begin n_fail++; $display("FAIL arith_depth: got %0d expected 0", ras_depth); end
    endtask

    task automatic test_call_ret();
        drive(10, 1, 0, 0, 0, 0, 100, 0, 0);
        n_checks++;
        if (ras_depth !== 4'd1) begin n_fail++; $display("FAIL call_depth: got %0d expected 1", ras_depth); end
        drive(105, 0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ras_depth !== 4'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ret_state: got depth=%0d ovf=%b unf=%b expected 0/0/0", ras_depth, ras_overflow, ras_underflow);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) drive(i, 1, 0, 0, 0, 0, 32'($urandom_range(0, 511)), 0, 0);
        n_checks++;
        if (ras_depth !== 4'd8 || ras_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow: got depth=%0d ovf=%b expected 8/1", ras_depth, ras_overflow);
        end
        for (int k = 0; k < 8; k++) drive(200, 0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ras_depth !== 4'd0 || ras_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got depth=%0d unf=%b expected 0/0", ras_depth, ras_underflow);
        end
        drive(200, 0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ras_underflow !== 1'b1 || ras_depth !== 4'd0) begin
            n_fail++;
            $display("FAIL underflow: got unf=%b depth=%0d expected 1/0", ras_underflow, ras_depth);
        end
        drive(210, 0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL flag_clr: got ovf=%b unf=%b expected 0/0", ras_overflow, ras_underflow);
        end
        drive(30, 0, 1, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (ras_underflow !== 1'b1) begin n_fail++; $display("FAIL set_wins: got unf=%b expected 1", ras_underflow); end
        drive(31, 1, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if (ras_underflow !== 1'b0 || ras_depth !== 4'd0) begin
            n_fail++;
            $display("FAIL clr_in_stall: got unf=%b depth=%0d expected 0/0", ras_underflow, ras_depth);
        end
    endtask

    task automatic test_stall_callret();
        drive(3, 1, 0, 0, 0, 0, 50, 0, 0);
        drive(6, 1, 0, 0, 0, 0, 60, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(40, 1, 0, 0, 0, 0, 90, 1, 0);
            n_checks++;
            if (ras_depth !== 4'd2) begin n_fail++; $display("FAIL stall_depth: got %0d expected 2", ras_depth); end
        end
        drive(20, 1, 1, 0, 0, 0, 90, 0, 0);
        n_checks++;
        if (ras_depth !== 4'd2 || ras_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL callret_state: got depth=%0d unf=%b expected 2/0", ras_depth, ras_underflow);
        end
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(70, 1, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ras_depth !== 4'd1 || ras_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL callret_empty: got depth=%0d unf=%b expected 1/1", ras_depth, ras_underflow);
        end
        drive(0, 0, 1, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset_mid();
        drive(11, 1, 0, 0, 0, 0, 80, 0, 0);
        drive(81, 1, 0, 0, 0, 0, 90, 0, 0);
        drive(91, 1, 0, 0, 0, 0, 99, 0, 0);
        pc_current = 9'd100; call = 1;
        #2 rst = 1;
        #1;
        n_checks++;
        if (ras_depth !== 4'd0) begin n_fail++; $display("FAIL async_reset: got depth=%0d expected 0", ras_depth); end
        idle();
        m.delete(); m_ovf = 0; m_unf = 0;
        #1 rst = 0;
        @(posedge clk); #1;
        drive(60, 0, 1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (ras_underflow !== 1'b1 || ras_depth !== 4'd0) begin
            n_fail++;
            $display("FAIL post_reset_ret: got unf=%b depth=%0d expected 1/0", ras_underflow, ras_depth);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_call_ret();
        test_overflow();
        test_stall_callret();
        test_reset_mid();
        @(negedge clk); #1;
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
